// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Decodes 5-byte command frames {SOF, CMD, ADDR, DATA, CHK} from the UART receive stage
//   into single-cycle register write/read strobes. It flags bad command codes, bad checksums
//   and inter-byte timeouts, and keeps a saturating error count.
// Ports
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   rx_valid   byte-ready level from the UART receiver (may stay high for many cycles)
//   rx_byte    received byte, valid while rx_valid is high
//   reg_wr_en  one-cycle write strobe
//   reg_rd_en  one-cycle read strobe
//   reg_addr   register address, held until the next strobe
//   reg_wdata  write data, held until the next write strobe
//   frame_err  one-cycle error pulse
//   err_cnt    saturating count of frame errors
//   busy       high whenever the FSM is not idle
module uart_cmd_parser #(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 104166
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StChk, StExec} state_e;

  state_e state_q, state_d;

  logic            rx_valid_q;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      chk_q, chk_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic accept;
  logic in_frame;
  logic tmo_expire;
  logic err;

  // Rising edge of rx_valid: one accept per byte however long the level is held.
  assign accept   = rx_valid & ~rx_valid_q;
  assign in_frame = (state_q != StIdle) && (state_q != StExec);
  // An accept in the expiry cycle takes priority over the timeout.
  assign tmo_expire = in_frame && !accept && (tmo_q == TmoLast);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && rx_byte == SOF_BYTE) state_d = StCmd;
      end
      StCmd: begin
        if (accept) begin
          if (rx_byte == CmdWrite || rx_byte == CmdRead) begin
            state_d = StAddr;
          end else begin
            state_d = StIdle;
            err     = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d = StIdle;
          err     = 1'b1;
        end
      end
      StAddr: begin
        if (accept) begin
          state_d = StData;
        end else if (tmo_expire) begin
          state_d = StIdle;
          err     = 1'b1;
        end
      end
      StData: begin
        if (accept) begin
          state_d = StChk;
        end else if (tmo_expire) begin
          state_d = StIdle;
          err     = 1'b1;
        end
      end
      StChk: begin
        if (accept) begin
          if (rx_byte == chk_q) begin
            state_d = StExec;
          end else begin
            state_d = StIdle;
            err     = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d = StIdle;
          err     = 1'b1;
        end
      end
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    chk_d       = chk_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = err;
    err_cnt_d   = err_cnt_q;

    if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    if (!in_frame || accept || tmo_expire) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (accept) begin
      unique case (state_q)
        StCmd: begin
          is_wr_d = (rx_byte == CmdWrite);
          chk_d   = rx_byte;
        end
        StAddr: begin
          addr_d = rx_byte;
          chk_d  = chk_q ^ rx_byte;
        end
        StData: begin
          data_d = rx_byte;
          chk_d  = chk_q ^ rx_byte;
        end
        default: ;
      endcase
    end

    if (state_q == StExec) begin
      reg_addr_d = addr_q;
      if (is_wr_q) begin
        reg_wdata_d = data_q;
        wr_en_d     = 1'b1;
      end else begin
        rd_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      tmo_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      chk_q       <= 8'h00;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      rx_valid_q  <= rx_valid;
      tmo_q       <= tmo_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != StIdle);

endmodule
